// File: rtl/mem_responder.sv
// Memory-side responder for the processor req/ack memory port: fixed wait states,
// one-cycle ack, word-addressed RAM with out-of-range error reporting.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int unsigned OFFS_W    = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned UPPER_LSB = OFFS_W + IDX_W;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic                  oor;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    txn_t             txn_q;
    txn_t             req_txn;
    logic             in_oor;
    logic             go_ack;
    logic             cur_we;
    logic             cur_oor;
    logic [IDX_W-1:0] cur_idx;
    logic             addr_offset_unused;

    // Byte-offset bits select nothing within a word; misalignment is not an error.
    assign addr_offset_unused = ^addr_i[OFFS_W-1:0];

    generate
        if (ADDR_WIDTH > UPPER_LSB) begin : g_range
            assign in_oor = |addr_i[ADDR_WIDTH-1:UPPER_LSB];
        end else begin : g_no_range
            assign in_oor = 1'b0;
        end
    endgenerate

    always_comb begin
        req_txn.we    = we_i;
        req_txn.oor   = in_oor;
        req_txn.idx   = addr_i[OFFS_W +: IDX_W];
        req_txn.wdata = wdata_i;
    end

    // With zero wait states the ack is launched straight from IDLE using the live request.
    assign cur_we  = (state_q == S_IDLE) ? req_txn.we  : txn_q.we;
    assign cur_oor = (state_q == S_IDLE) ? req_txn.oor : txn_q.oor;
    assign cur_idx = (state_q == S_IDLE) ? req_txn.idx : txn_q.idx;

    assign go_ack = ((state_q == S_IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));

    // Transaction capture; only meaningful once accepted, so no reset needed.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_IDLE) && req_i) begin
            txn_q <= req_txn;
        end
    end

    // Write commits at the end of the ACK cycle unless reset discards it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_ACK) && txn_q.we && !txn_q.oor) begin
            mem[txn_q.idx] <= txn_q.wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (go_ack) begin
                ack_o <= 1'b1;
                err_o <= cur_oor;
                if (!cur_we) begin
                    rdata_o <= cur_oor ? '0 : mem[cur_idx];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        busy_o  <= 1'b1;
                        state_q <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 1, 0 and 3 wait states.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [15:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int checks = 0;
    int errors = 0;

    logic        cap_ack   [32];
    logic        cap_err   [32];
    logic        cap_busy  [32];
    logic [15:0] cap_rdata [32];

    mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .WAIT_CYCLES(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0])
    );
    mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1])
    );
    mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]), .busy_o(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request at cycle 0, hold req for 'hold' cycles, capture outputs for cycles 1..ncyc.
    task automatic run_txn(input int d, input logic w, input logic [15:0] a,
                           input logic [15:0] wd, input int hold, input int ncyc);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == hold) req[d] = 1'b0;
            cap_ack[c]   = ack[d];
            cap_err[c]   = err[d];
            cap_busy[c]  = busy[d];
            cap_rdata[c] = rdata[d];
        end
        req[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack[i] !== 1'b0) begin
                errors++; $display("FAIL reset_ack inst=%0d got %b expected 0", i, ack[i]);
            end
            checks++;
            if (err[i] !== 1'b0) begin
                errors++; $display("FAIL reset_err inst=%0d got %b expected 0", i, err[i]);
            end
            checks++;
            if (busy[i] !== 1'b0) begin
                errors++; $display("FAIL reset_busy inst=%0d got %b expected 0", i, busy[i]);
            end
            checks++;
            if (rdata[i] !== 16'h0000) begin
                errors++; $display("FAIL reset_rdata inst=%0d got %h expected 0000", i, rdata[i]);
            end
        end
    endtask

    task automatic test_write_read();
        run_txn(0, 1'b1, 16'h0004, 16'hBEEF, 1, 4);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (cap_ack[c] !== (c == 2)) begin
                errors++; $display("FAIL wr_ack c=%0d got %b expected %b", c, cap_ack[c], c == 2);
            end
            checks++;
            if (cap_busy[c] !== (c <= 2)) begin
                errors++; $display("FAIL wr_busy c=%0d got %b expected %b", c, cap_busy[c], c <= 2);
            end
        end
        checks++;
        if (cap_err[2] !== 1'b0 || cap_rdata[2] !== 16'h0000) begin
            errors++; $display("FAIL wr_err_rdata got err=%b rdata=%h expected err=0 rdata=0000",
                               cap_err[2], cap_rdata[2]);
        end
        run_txn(0, 1'b0, 16'h0004, 16'h0000, 1, 4);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (cap_ack[c] !== (c == 2)) begin
                errors++; $display("FAIL rd_ack c=%0d got %b expected %b", c, cap_ack[c], c == 2);
            end
        end
        checks++;
        if (cap_rdata[2] !== 16'hBEEF || cap_err[2] !== 1'b0) begin
            errors++; $display("FAIL rd_data got rdata=%h err=%b expected BEEF err=0",
                               cap_rdata[2], cap_err[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic        exp_ack;
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            run_txn(1, 1'b1, 16'(2 * k), words[k], 1, 2);
            checks++;
            if (cap_ack[1] !== 1'b1) begin
                errors++; $display("FAIL w0_preload_ack k=%0d got %b expected 1", k, cap_ack[1]);
            end
        end
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 16'h0000;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 2) addr[1] = 16'h0002;
            if (c == 4) addr[1] = 16'h0004;
            if (c == 5) req[1] = 1'b0;
            exp_ack = (c == 1) || (c == 3) || (c == 5);
            checks++;
            if (ack[1] !== exp_ack) begin
                errors++; $display("FAIL b2b_ack c=%0d got %b expected %b", c, ack[1], exp_ack);
            end
            checks++;
            if (busy[1] !== exp_ack) begin
                errors++; $display("FAIL b2b_busy c=%0d got %b expected %b", c, busy[1], exp_ack);
            end
            if (c <= 6) begin
                checks++;
                if (rdata[1] !== words[(c - 1) / 2]) begin
                    errors++; $display("FAIL b2b_rdata c=%0d got %h expected %h",
                                       c, rdata[1], words[(c - 1) / 2]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        run_txn(0, 1'b1, 16'h0000, 16'h5A5A, 1, 4);
        run_txn(0, 1'b1, 16'h0200, 16'h1234, 1, 4);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (cap_ack[c] !== (c == 2) || cap_err[c] !== (c == 2)) begin
                errors++; $display("FAIL oor_wr c=%0d got ack=%b err=%b expected %b/%b",
                                   c, cap_ack[c], cap_err[c], c == 2, c == 2);
            end
        end
        run_txn(0, 1'b0, 16'h0200, 16'h0000, 1, 4);
        checks++;
        if (cap_ack[2] !== 1'b1 || cap_err[2] !== 1'b1 || cap_rdata[2] !== 16'h0000) begin
            errors++; $display("FAIL oor_rd got ack=%b err=%b rdata=%h expected 1/1/0000",
                               cap_ack[2], cap_err[2], cap_rdata[2]);
        end
        checks++;
        if (cap_err[3] !== 1'b0) begin
            errors++; $display("FAIL oor_err_clear got %b expected 0", cap_err[3]);
        end
        run_txn(0, 1'b0, 16'h0000, 16'h0000, 1, 4);
        checks++;
        if (cap_rdata[2] !== 16'h5A5A || cap_err[2] !== 1'b0) begin
            errors++; $display("FAIL oor_no_alias got rdata=%h err=%b expected 5A5A err=0",
                               cap_rdata[2], cap_err[2]);
        end
        run_txn(0, 1'b1, 16'h01FE, 16'h0FE0, 1, 4);
        run_txn(0, 1'b0, 16'h01FE, 16'h0000, 1, 4);
        checks++;
        if (cap_rdata[2] !== 16'h0FE0 || cap_err[2] !== 1'b0 || cap_ack[2] !== 1'b1) begin
            errors++; $display("FAIL last_word got rdata=%h err=%b ack=%b expected 0FE0/0/1",
                               cap_rdata[2], cap_err[2], cap_ack[2]);
        end
    endtask

    task automatic test_req_drop();
        run_txn(2, 1'b1, 16'h0004, 16'hCAFE, 1, 6);
        checks++;
        if (cap_ack[4] !== 1'b1) begin
            errors++; $display("FAIL w3_wr_ack got %b expected 1", cap_ack[4]);
        end
        run_txn(2, 1'b0, 16'h0004, 16'h0000, 1, 8);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (cap_ack[c] !== (c == 4)) begin
                errors++; $display("FAIL drop_ack c=%0d got %b expected %b", c, cap_ack[c], c == 4);
            end
            checks++;
            if (cap_busy[c] !== (c <= 4)) begin
                errors++; $display("FAIL drop_busy c=%0d got %b expected %b", c, cap_busy[c], c <= 4);
            end
        end
        checks++;
        if (cap_rdata[4] !== 16'hCAFE) begin
            errors++; $display("FAIL drop_rdata got %h expected CAFE", cap_rdata[4]);
        end
    endtask

    task automatic test_reset_abort();
        // Reset during WAIT (one wait state instance).
        run_txn(0, 1'b1, 16'h0010, 16'h5555, 1, 4);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hAAAA;
        tick();
        req[0] = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            checks++;
            if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++; $display("FAIL rst_wait c=%0d got ack=%b busy=%b expected 0/0",
                                   c, ack[0], busy[0]);
            end
            tick();
        end
        run_txn(0, 1'b0, 16'h0010, 16'h0000, 1, 4);
        checks++;
        if (cap_rdata[2] !== 16'h5555 || cap_ack[2] !== 1'b1) begin
            errors++; $display("FAIL rst_wait_mem got rdata=%h ack=%b expected 5555/1",
                               cap_rdata[2], cap_ack[2]);
        end
        // Reset in the ACK cycle itself (three wait state instance).
        run_txn(2, 1'b1, 16'h0020, 16'h1357, 1, 6);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 16'h7777;
        tick();
        req[2] = 1'b0;
        repeat (3) tick();
        checks++;
        if (ack[2] !== 1'b1) begin
            errors++; $display("FAIL rst_ack_pre got ack=%b expected 1", ack[2]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
            errors++; $display("FAIL rst_ack_post got ack=%b busy=%b expected 0/0", ack[2], busy[2]);
        end
        run_txn(2, 1'b0, 16'h0020, 16'h0000, 1, 6);
        checks++;
        if (cap_rdata[4] !== 16'h1357) begin
            errors++; $display("FAIL rst_ack_mem got %h expected 1357", cap_rdata[4]);
        end
    endtask

    task automatic test_odd_addr_stream();
        int   nack;
        logic prev;
        nack = 0;
        prev = 1'b0;
        run_txn(0, 1'b0, 16'h0005, 16'h0000, 9, 10);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (cap_ack[c] === 1'b1 && prev === 1'b1) begin
                errors++; $display("FAIL ack_double c=%0d got 1 after 1 expected 0", c);
            end
            if (cap_ack[c] === 1'b1) begin
                nack++;
                checks++;
                if (cap_rdata[c] !== 16'hBEEF || cap_err[c] !== 1'b0) begin
                    errors++; $display("FAIL odd_rd c=%0d got rdata=%h err=%b expected BEEF err=0",
                                       c, cap_rdata[c], cap_err[c]);
                end
            end
            prev = cap_ack[c];
        end
        checks++;
        if (nack != 3 || cap_ack[2] !== 1'b1 || cap_ack[5] !== 1'b1 || cap_ack[8] !== 1'b1) begin
            errors++; $display("FAIL odd_ack_count got %0d acks expected 3 at cycles 2,5,8", nack);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0000; wdata[i] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_req_drop();
        test_reset_abort();
        test_odd_addr_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
